binary_to_ascii: RTL and testbench



---
 rtl/binary_to_ascii.sv | 44 ++++
 tb/tb_binary_to_ascii.sv | 132 +++++++++++++
 2 files changed

// File: rtl/binary_to_ascii.sv
// Registered binary digit to ASCII hex character converter.
// One-cycle latency; out-of-range inputs map to '?' with invalid set.
module binary_to_ascii (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] binary_in,
    output logic [7:0] ascii_out,
    output logic       invalid
);

    logic [7:0] next_ascii;
    logic       next_invalid;

    // 'A' - 10 = 8'h37, so letters need a single add like digits do
    always_comb begin
        next_ascii   = 8'h3F;
        next_invalid = 1'b1;
        unique case (1'b1)
            (binary_in <= 8'd9): begin
                next_ascii   = 8'h30 + binary_in;
                next_invalid = 1'b0;
            end
            (binary_in >= 8'd10 && binary_in <= 8'd15): begin
                next_ascii   = 8'h37 + binary_in;
                next_invalid = 1'b0;
            end
            (binary_in >= 8'd16): begin
                next_ascii   = 8'h3F;
                next_invalid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ascii_out <= 8'h00;
            invalid   <= 1'b0;
        end else begin
            ascii_out <= next_ascii;
            invalid   <= next_invalid;
        end
    end

endmodule

// File: tb/tb_binary_to_ascii.sv
// Scoreboard bench for binary_to_ascii.
// Expected {invalid, ascii} pushed on drive, popped one edge later.
module tb_binary_to_ascii;

    logic       clock;
    logic       reset_n;
    logic [7:0] binary_in;
    logic [7:0] ascii_out;
    logic       invalid;

    int vectors;
    int miscompares;
    logic [8:0] sb_q[$];

    binary_to_ascii dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .binary_in (binary_in),
        .ascii_out (ascii_out),
        .invalid   (invalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [8:0] model(input logic [7:0] v);
        if (v < 8'd10)
            return {1'b0, 8'h30 + v};
        else if (v < 8'd16)
            return {1'b0, 8'h41 + (v - 8'd10)};
        else
            return {1'b1, 8'h3F};
    endfunction

    task automatic check(input string tag, input logic [8:0] got,
                         input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got inv=%b ascii=%h, expected inv=%b ascii=%h",
                     tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        @(negedge clock);
        binary_in = v;
        sb_q.push_back(model(v));
    endtask

    task automatic collect(input string tag);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_empty"}, {invalid, ascii_out}, 9'h1FF);
        end else begin
            check(tag, {invalid, ascii_out}, sb_q.pop_front());
        end
    endtask

    task automatic apply(input string tag, input logic [7:0] v);
        drive(v);
        collect(tag);
    endtask

    initial begin
        logic [7:0] seq[];
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        binary_in   = 8'h05;

        // held in reset with clock running
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("reset_hold", {invalid, ascii_out}, 9'h000);
        end
        @(negedge clock);
        reset_n = 1'b1;
        sb_q.push_back(model(8'h05));
        collect("release_first");

        apply("dec0", 8'd0);
        apply("dec9", 8'd9);
        apply("dec5", 8'd5);

        for (int i = 0; i < 16; i++)
            apply("sweep", 8'(i));

        apply("oor16", 8'd16);
        apply("oorFF", 8'hFF);
        apply("oor80", 8'h80);
        apply("back3", 8'd3);

        // asynchronous clear between edges
        apply("pre_async", 8'd12);
        @(negedge clock);
        binary_in = 8'h0A;
        #1;
        reset_n = 1'b0;
        #1;
        check("async_clear", {invalid, ascii_out}, 9'h000);
        @(posedge clock);
        #1;
        check("reset_mid", {invalid, ascii_out}, 9'h000);
        @(negedge clock);
        reset_n = 1'b1;
        sb_q.push_back(model(8'h0A));
        collect("release_0A");

        // boundaries back to back, pipelined drive and collect
        seq = '{8'd9, 8'd10, 8'd15, 8'd16, 8'd255, 8'd0};
        foreach (seq[i]) begin
            drive(seq[i]);
            collect("boundary");
        end

        for (int i = 0; i < 40; i++)
            apply("random", 8'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++)
            apply("rand_digit", 8'($urandom_range(0, 17)));

        if (sb_q.size() != 0)
            check("sb_leftover", 9'(sb_q.size()), 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
